clean_pulse_gen: RTL and testbench
==================================

// Module: clean_pulse_gen
// PURPOSE
//  Transmit-side companion to the input glitch filter. Turns single-cycle
//  request strobes into clean output pulses with a guaranteed minimum HIGH
//  width and LOW gap, so a far-end glitch filter always accepts them.
//  Requests that arrive during a pulse are queued in a saturating counter.
//  Sits between control logic (trigger/TX sequencer) and the driven line.
// PARAMETERS
//  CTR_WIDTH   20  width of high_len/low_len and the internal width counter
//  PEND_WIDTH  4   width of the pending-request counter (max 2^PEND_WIDTH-1)
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset, synchronous, active-high
//  en         in   1           1 = pulses may be launched; 0 = requests only queue
//  req        in   1           request strobe; each high cycle = one pulse
//  high_len   in   CTR_WIDTH   HIGH width in clk cycles (0 treated as 1)
//  low_len    in   CTR_WIDTH   LOW gap after each pulse, in cycles (0 treated as 1)
//  pulse_out  out  1           clean output pulse, registered
//  busy       out  1           1 while state != IDLE
//  done       out  1           1-cycle strobe on the last LOW-gap cycle of each pulse
//  pend_cnt   out  PEND_WIDTH  queued requests not yet launched
//  overflow   out  1           sticky; set when a request is dropped (queue full)
// BEHAVIOUR
//  Reset: state=IDLE, pulse_out=0, busy=0, done=0, pend_cnt=0, overflow=0,
//   ctr=0. Reset mid-pulse drops pulse_out on the next edge; queue is discarded.
//  States: IDLE, HIGH, LOW. All outputs are registered.
//  launch = en && (pend_cnt!=0 || req) && (state==IDLE || (state==LOW && ctr==1)).
//  IDLE: on launch -> HIGH, pulse_out<=1, ctr<=max(high_len,1).
//   Latency: req high in cycle k from IDLE with en=1 -> pulse_out=1 from k+1.
//  HIGH: ctr decrements each cycle; at ctr==1 -> LOW, pulse_out<=0,
//   ctr<=max(low_len,1). pulse_out is high for exactly max(high_len,1) cycles.
//  LOW: ctr decrements; done=1 in the cycle ctr==1. At ctr==1: if launch,
//   -> HIGH (back-to-back, period = H+L); otherwise -> IDLE.
//  high_len/low_len are sampled only on entry to HIGH/LOW; changes mid-phase
//   take effect on the next phase.
//  Queue: pend_cnt += req, -= launch. With req and launch in the same cycle,
//   pend_cnt is unchanged (the request is consumed directly).
//   If pend_cnt == all-ones, req without launch -> request dropped, overflow<=1,
//   pend_cnt holds. overflow clears only on rst.
//  en=0: no new launch; a pulse in progress finishes its HIGH and LOW phases,
//   then the block enters IDLE. Requests keep queuing. When en returns to 1,
//   queued pulses launch from the next edge.
//  busy = (state != IDLE); it stays 1 across back-to-back pulses.
// TESTING
//  1 H=3,L=2, en=1, single req at cycle 10 -> pulse_out=1 cycles 11-13, 0 from
//    14; done=1 at cycle 15; busy=1 cycles 11-15; idle at 16.
//  2 H=3,L=2, 3 reqs in cycles 10,11,12 -> 3 pulses at 11-13,16-18,21-23;
//    pend_cnt peaks at 2; no overflow.
//  3 high_len=0,low_len=0, req -> 1-cycle HIGH, 1-cycle LOW; two queued reqs
//    give the pattern 1,0,1,0.
//  4 en=0, 17 reqs with PEND_WIDTH=4 -> pend_cnt=15, overflow=1, pulse_out=0;
//    then en=1 -> exactly 15 pulses, pend_cnt returns to 0.
//  5 rst during the 2nd HIGH cycle with 2 reqs pending -> next cycle pulse_out=0,
//    pend_cnt=0, busy=0, overflow=0; no further pulses.
//  6 high_len changed from 3 to 5 mid-pulse -> current pulse is 3 cycles, the
//    next is 5; req in the same cycle as a LOW->HIGH relaunch -> pend_cnt unchanged.

Source files
------------

// File: rtl/clean_pulse_if.sv
// Request/pulse bundle for clean_pulse_gen. The master side is the control logic.
// The slave side is the pulse generator.
interface clean_pulse_if #(
    parameter int CTR_WIDTH  = 20,
    parameter int PEND_WIDTH = 4
);
    logic                  en;
    logic                  req;
    logic [CTR_WIDTH-1:0]  high_len;
    logic [CTR_WIDTH-1:0]  low_len;
    logic                  pulse_out;
    logic                  busy;
    logic                  done;
    logic [PEND_WIDTH-1:0] pend_cnt;
    logic                  overflow;

    modport master (
        output en, req, high_len, low_len,
        input  pulse_out, busy, done, pend_cnt, overflow
    );

    modport slave (
        input  en, req, high_len, low_len,
        output pulse_out, busy, done, pend_cnt, overflow
    );
endinterface

// File: rtl/clean_pulse_gen.sv
// Turns request strobes into pulses with a guaranteed minimum HIGH width and LOW gap.
// Requests that arrive while a pulse is running wait in a saturating counter.
module clean_pulse_gen #(
    parameter int CTR_WIDTH  = 20,
    parameter int PEND_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    clean_pulse_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CTR_WIDTH-1:0]  CTR_ONE  = 1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = 1;

    state_t                state, state_nxt;
    logic [CTR_WIDTH-1:0]  ctr, ctr_nxt;
    logic [PEND_WIDTH-1:0] pend, pend_nxt;
    logic                  pulse_q, pulse_nxt;
    logic                  done_q, done_nxt;
    logic                  busy_q;
    logic                  ovf_q, ovf_nxt;
    logic                  slot_free;
    logic                  launch;

    function automatic logic [CTR_WIDTH-1:0] at_least_one(input logic [CTR_WIDTH-1:0] v);
        return (v == '0) ? CTR_ONE : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ctr     <= '0;
            pend    <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ctr     <= ctr_nxt;
            pend    <= pend_nxt;
            pulse_q <= pulse_nxt;
            done_q  <= done_nxt;
            busy_q  <= (state_nxt != IDLE);
            ovf_q   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        pulse_nxt = pulse_q;
        pend_nxt  = pend;
        ovf_nxt   = ovf_q;

        // A new pulse may start from IDLE or on the final cycle of the LOW gap.
        slot_free = (state == IDLE) || (state == LOW && ctr == CTR_ONE);
        launch    = bus.en && (pend != '0 || bus.req) && slot_free;

        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = HIGH;
                    pulse_nxt = 1'b1;
                    ctr_nxt   = at_least_one(bus.high_len);
                end
            end
            HIGH: begin
                if (ctr == CTR_ONE) begin
                    state_nxt = LOW;
                    pulse_nxt = 1'b0;
                    ctr_nxt   = at_least_one(bus.low_len);
                end else begin
                    ctr_nxt = ctr - CTR_ONE;
                end
            end
            LOW: begin
                if (ctr == CTR_ONE) begin
                    if (launch) begin
                        state_nxt = HIGH;
                        pulse_nxt = 1'b1;
                        ctr_nxt   = at_least_one(bus.high_len);
                    end else begin
                        state_nxt = IDLE;
                        ctr_nxt   = '0;
                    end
                end else begin
                    ctr_nxt = ctr - CTR_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                pulse_nxt = 1'b0;
                ctr_nxt   = '0;
            end
        endcase

        done_nxt = (state_nxt == LOW) && (ctr_nxt == CTR_ONE);

        // A request launched in its own cycle never touches the queue.
        case ({bus.req, launch})
            2'b10: begin
                if (&pend) ovf_nxt = 1'b1;
                else       pend_nxt = pend + PEND_ONE;
            end
            2'b01:   pend_nxt = pend - PEND_ONE;
            default: pend_nxt = pend;
        endcase
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pend_cnt  = pend;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_clean_pulse_gen.sv
// Bench for clean_pulse_gen: vector table through a scoreboard queue,
// followed by hand-written multi-cycle sequences.
module tb_clean_pulse_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clean_pulse_if #(.CTR_WIDTH(20), .PEND_WIDTH(4)) bus();
    clean_pulse_gen #(.CTR_WIDTH(20), .PEND_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic       r, e, q;
        int         hl, ll;
        logic       p, b, d;
        logic [3:0] pc;
        logic       ov;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[21];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic e, logic q, int hl, int ll,
                                logic p, logic b, logic d, int pc, logic ov);
        vec_t v;
        v.r = r; v.e = e; v.q = q; v.hl = hl; v.ll = ll;
        v.p = p; v.b = b; v.d = d; v.pc = pc[3:0]; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic q, input int hl, input int ll);
        rst          = r;
        bus.en       = e;
        bus.req      = q;
        bus.high_len = hl[19:0];
        bus.low_len  = ll[19:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       v, e;
        logic [0:17] obs, expv;
        int         peak, pulses, width, hi_cnt;
        logic       prev;

        drive(1, 0, 0, 3, 2);

        // single request, H=3 L=2
        tbl[0]  = mk(1,0,0,3,2, 0,0,0,0,0);
        tbl[1]  = mk(0,1,1,3,2, 1,1,0,0,0);
        tbl[2]  = mk(0,1,0,3,2, 1,1,0,0,0);
        tbl[3]  = mk(0,1,0,3,2, 1,1,0,0,0);
        tbl[4]  = mk(0,1,0,3,2, 0,1,0,0,0);
        tbl[5]  = mk(0,1,0,3,2, 0,1,1,0,0);
        tbl[6]  = mk(0,1,0,3,2, 0,0,0,0,0);
        tbl[7]  = mk(0,1,0,0,0, 0,0,0,0,0);
        // zero lengths act as 1: pattern 1,0,1,0
        tbl[8]  = mk(0,1,1,0,0, 1,1,0,0,0);
        tbl[9]  = mk(0,1,1,0,0, 0,1,1,1,0);
        tbl[10] = mk(0,1,0,0,0, 1,1,0,0,0);
        tbl[11] = mk(0,1,0,0,0, 0,1,1,0,0);
        tbl[12] = mk(0,1,0,0,0, 0,0,0,0,0);
        // en dropped mid-pulse: pulse completes, queued request waits for en
        tbl[13] = mk(0,1,1,2,1, 1,1,0,0,0);
        tbl[14] = mk(0,0,1,2,1, 1,1,0,1,0);
        tbl[15] = mk(0,0,0,2,1, 0,1,1,1,0);
        tbl[16] = mk(0,0,0,2,1, 0,0,0,1,0);
        tbl[17] = mk(0,1,0,2,1, 1,1,0,0,0);
        tbl[18] = mk(0,1,0,2,1, 1,1,0,0,0);
        tbl[19] = mk(0,1,0,2,1, 0,1,1,0,0);
        tbl[20] = mk(0,1,0,2,1, 0,0,0,0,0);

        for (int i = 0; i < 21; i++) begin
            v = tbl[i];
            drive(v.r, v.e, v.q, v.hl, v.ll);
            sb.push_back(v);
            tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d", i),
                {bus.pulse_out, bus.busy, bus.done, bus.pend_cnt, bus.overflow},
                {e.p, e.b, e.d, e.pc, e.ov});
        end

        // three back-to-back requests, H=3 L=2
        drive(1, 0, 0, 3, 2); tick();
        peak = 0;
        for (int k = 0; k < 18; k++) begin
            drive(0, 1, k < 3, 3, 2);
            tick();
            obs[k]  = bus.pulse_out;
            expv[k] = ((k % 5) < 3) && (k < 15);
            if (int'(bus.pend_cnt) > peak) peak = int'(bus.pend_cnt);
        end
        chk("burst3_pattern", 32'(obs), 32'(expv));
        chk("burst3_peak", peak, 2);
        chk("burst3_ovf", bus.overflow, 0);

        // queue saturation with en=0, then drain
        drive(1, 0, 0, 2, 1); tick();
        hi_cnt = 0;
        for (int k = 0; k < 17; k++) begin
            drive(0, 0, 1, 2, 1);
            tick();
            if (bus.pulse_out) hi_cnt++;
            if (k == 14) chk("sat_no_ovf_at_15", {bus.pend_cnt, bus.overflow}, {4'd15, 1'b0});
        end
        chk("sat_pend", bus.pend_cnt, 15);
        chk("sat_ovf", bus.overflow, 1);
        chk("sat_no_pulse", hi_cnt, 0);
        drive(0, 1, 0, 2, 1);
        tick();
        chk("drain_first", {bus.pulse_out, bus.pend_cnt}, {1'b1, 4'd14});
        pulses = 1;
        prev   = 1'b1;
        for (int c = 0; c < 100 && bus.busy; c++) begin
            tick();
            if (bus.pulse_out && !prev) pulses++;
            prev = bus.pulse_out;
        end
        chk("drain_idle", bus.busy, 0);
        chk("drain_count", pulses, 15);
        chk("drain_pend", bus.pend_cnt, 0);

        // reset in 2nd HIGH cycle with two pending; overflow is still set here
        drive(0, 0, 1, 3, 2); tick();
        drive(0, 1, 1, 3, 2); tick();
        drive(0, 1, 1, 3, 2); tick();
        chk("prerst", {bus.pulse_out, bus.pend_cnt, bus.overflow}, {1'b1, 4'd2, 1'b1});
        drive(1, 1, 0, 3, 2); tick();
        chk("rst_mid", {bus.pulse_out, bus.busy, bus.done, bus.pend_cnt, bus.overflow}, 8'h00);
        hi_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            drive(0, 1, 0, 3, 2);
            tick();
            if (bus.pulse_out || bus.busy) hi_cnt++;
        end
        chk("rst_quiet", hi_cnt, 0);

        // high_len change mid-pulse; req coinciding with relaunch
        drive(1, 0, 0, 3, 2); tick();
        drive(0, 1, 1, 3, 2); tick();
        drive(0, 1, 1, 5, 2); tick();
        drive(0, 1, 0, 5, 2); tick();
        chk("len_first_hi3", bus.pulse_out, 1);
        tick();
        chk("len_first_fall", {bus.pulse_out, bus.pend_cnt}, {1'b0, 4'd1});
        tick();
        chk("len_done", bus.done, 1);
        drive(0, 1, 1, 5, 2); tick();
        chk("relaunch_req", {bus.pulse_out, bus.pend_cnt}, {1'b1, 4'd1});
        drive(0, 1, 0, 5, 2);
        width = 1;
        for (int c = 0; c < 20 && bus.pulse_out; c++) begin
            tick();
            if (bus.pulse_out) width++;
        end
        chk("len_second_w5", width, 5);
        for (int c = 0; c < 60 && bus.busy; c++) tick();
        chk("len_final_idle", {bus.busy, bus.pend_cnt}, {1'b0, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
